alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu.sv | 39 +++
 rtl/alu_regfile.sv | 26 ++
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;
  localparam int DW   = 4;
  localparam int NREG = 4;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_SUB  = 3'b001,
    CMD_AND  = 3'b010,
    CMD_OR   = 3'b011,
    CMD_LOAD = 3'b100
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic s;
  } flags_t;
endpackage

// File: rtl/alu.sv
// 4-function ALU (ADD, SUB, AND, OR) with Z/C/V/S flags; C on SUB means "no borrow".
module alu #(
  parameter int DW = 4
) (
  input  logic [1:0]    select,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c,
  output logic          v,
  output logic          s
);
  logic [DW:0] ext;

  always_comb begin
    ext = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (select)
      2'b00: begin
        ext = {1'b0, a} + {1'b0, b};
        c   = ext[DW];
        v   = (a[DW-1] == b[DW-1]) && (ext[DW-1] != a[DW-1]);
      end
      2'b01: begin
        ext = {1'b0, a} - {1'b0, b};
        c   = ~ext[DW];
        v   = (a[DW-1] != b[DW-1]) && (ext[DW-1] != a[DW-1]);
      end
      2'b10:   ext = {1'b0, a & b};
      default: ext = {1'b0, a | b};
    endcase
  end

  assign result = ext[DW-1:0];
  assign z      = (result == '0);
  assign s      = result[DW-1];
endmodule

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write port.
module alu_regfile #(
  parameter int NREG = 4,
  parameter int DW   = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_a_i,
  output logic [DW-1:0] rd_a_o,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i
);
  logic [NREG-1:0][DW-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (!rst_n)    regs_q       <= '0;
    else if (we_i) regs_q[wa_i] <= wd_i;
  end

  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];
endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the external ALU: IDLE -> EXEC (one cycle) -> RESP, with
// register file write-back and a status flag register.
module alu_op_sequencer #(
  parameter int NREG = 4,
  parameter int DW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_cmd,
  input  logic [1:0]    req_dst,
  input  logic [1:0]    req_src_a,
  input  logic [1:0]    req_src_b,
  input  logic [DW-1:0] req_imm,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic [3:0]    resp_flags,
  output logic          resp_err,
  output logic [1:0]    alu_select,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          alu_s
);
  import alu_seq_pkg::*;

  state_t        state_q;
  logic [2:0]    cmd_q;
  logic [1:0]    dst_q;
  logic [DW-1:0] imm_q;
  flags_t        flags_q, flags_d;
  logic          rdy_q, rvld_q, rerr_q;
  logic [DW-1:0] rdata_q;
  flags_t        rflags_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] a_q, b_q;

  logic [DW-1:0] rd_a, rd_b, wd;
  logic          is_op, is_load, we;

  assign is_op   = ~cmd_q[2];
  assign is_load = (cmd_q == CMD_LOAD);
  assign we      = (state_q == EXEC) && (is_op || is_load);
  assign wd      = is_load ? imm_q : alu_result;
  assign flags_d = is_op ? flags_t'({alu_z, alu_c, alu_v, alu_s}) : flags_q;

  // Operands are read while the command is accepted; nothing writes in IDLE,
  // so this matches an EXEC-time read and keeps alu_a/alu_b held afterwards.
  alu_regfile #(.NREG(NREG), .DW(DW)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_a_i (req_src_a),
    .rd_a_o (rd_a),
    .ra_b_i (req_src_b),
    .rd_b_o (rd_b),
    .we_i   (we),
    .wa_i   (dst_q),
    .wd_i   (wd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      flags_q  <= '0;
      rdy_q    <= 1'b0;
      rvld_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      rflags_q <= '0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (req_valid && rdy_q) begin
            cmd_q   <= req_cmd;
            dst_q   <= req_dst;
            imm_q   <= req_imm;
            sel_q   <= req_cmd[1:0];
            a_q     <= rd_a;
            b_q     <= rd_b;
            rdy_q   <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          flags_q  <= flags_d;
          rflags_q <= flags_d;
          rdata_q  <= we ? wd : '0;
          rerr_q   <= ~(is_op || is_load);
          rvld_q   <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            rvld_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = rdy_q;
  assign resp_valid = rvld_q;
  assign resp_data  = rdata_q;
  assign resp_flags = rflags_q;
  assign resp_err   = rerr_q;
  assign alu_select = sel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer driving the real alu.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [2:0] req_cmd;
  logic [1:0] req_dst, req_src_a, req_src_b;
  logic [3:0] req_imm;
  logic       resp_valid, resp_ready;
  logic [3:0] resp_data, resp_flags;
  logic       resp_err;
  logic [1:0] alu_select;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_z, alu_c, alu_v, alu_s;

  typedef struct {
    logic [3:0] data;
    logic [3:0] flags;
    logic       err;
    logic       chk_data;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rm[4];
  logic [3:0] fm;
  int         nchk = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.NREG(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_dst(req_dst), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_imm(req_imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s)
  );

  alu #(.DW(4)) u_alu (
    .select(alu_select), .a(alu_a), .b(alu_b),
    .result(alu_result), .z(alu_z), .c(alu_c), .v(alu_v), .s(alu_s)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check(tag, dut.u_rf.regs_q[i], rm[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rm[i] = 4'h0;
    fm = 4'h0;
  endtask

  // Drive one command, predict it, check EXEC lines, then check the response;
  // hold>0 keeps resp_ready low (with a stray req_valid) for that many cycles.
  task automatic run_cmd(input logic [2:0] cmd, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb_, input logic [3:0] imm, input int hold);
    exp_t       e, g;
    logic [3:0] a, b, r, f;
    logic [4:0] x;
    int         n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
    a = rm[sa];
    b = rm[sb_];
    f = fm;
    r = 4'h0;
    case (cmd)
      3'd0: begin
        x = {1'b0, a} + {1'b0, b};
        r = x[3:0];
        f = {r == 4'h0, x[4], (a[3] == b[3]) && (r[3] != a[3]), r[3]};
      end
      3'd1: begin
        x = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = x[3:0];
        f = {r == 4'h0, x[4], (a[3] != b[3]) && (r[3] != a[3]), r[3]};
      end
      3'd2: begin r = a & b; f = {r == 4'h0, 1'b0, 1'b0, r[3]}; end
      3'd3: begin r = a | b; f = {r == 4'h0, 1'b0, 1'b0, r[3]}; end
      3'd4: r = imm;
      default: ;
    endcase
    e.data     = r;
    e.flags    = f;
    e.err      = (cmd > 3'd4);
    e.chk_data = (cmd <= 3'd4);
    if (cmd <= 3'd4) rm[dst] = r;
    fm = f;
    sb.push_back(e);

    req_valid  = 1'b1;
    req_cmd    = cmd;
    req_dst    = dst;
    req_src_a  = sa;
    req_src_b  = sb_;
    req_imm    = imm;
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("exec_rvld", resp_valid, 0);
    check("exec_rdy", req_ready, 0);
    check("exec_sel", alu_select, cmd[1:0]);
    check("exec_a", alu_a, a);
    check("exec_b", alu_b, b);
    @(negedge clk);
    check("lat2_rvld", resp_valid, 1);
    g = sb.pop_front();
    if (g.chk_data) check("data", resp_data, g.data);
    check("flags", resp_flags, g.flags);
    check("err", resp_err, g.err);
    if (hold > 0) begin
      req_valid = 1'b1;
      req_cmd   = 3'b100;
      req_dst   = 2'd0;
      req_imm   = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_vld", resp_valid, 1);
        check("bp_data", resp_data, g.data);
        check("bp_flags", resp_flags, g.flags);
        check("bp_rdy", req_ready, 0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check("post_rvld", resp_valid, 0);
    check("post_rdy", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_dst = '0;
    req_src_a = '0; req_src_b = '0; req_imm = '0; resp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdy_low", req_ready, 0);
    check("rst_rvld", resp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", req_ready, 1);
    check("rel_rvld", resp_valid, 0);
    check("rel_data", resp_data, 0);
    check("rel_flags", resp_flags, 0);
    check("rel_err", resp_err, 0);
    check_regs("rst_regs");

    run_cmd(3'b100, 2'd0, 2'd0, 2'd0, 4'h5, 0);
    run_cmd(3'b000, 2'd0, 2'd0, 2'd0, 4'h0, 0);   // 5+5 = 0xA

    run_cmd(3'b100, 2'd1, 2'd0, 2'd0, 4'hF, 0);
    run_cmd(3'b100, 2'd2, 2'd0, 2'd0, 4'h1, 0);
    run_cmd(3'b000, 2'd3, 2'd1, 2'd2, 4'h0, 0);   // 0xF+0x1 -> 0, Z=1 C=1
    run_cmd(3'b100, 2'd1, 2'd0, 2'd0, 4'h4, 0);   // flags kept

    run_cmd(3'b100, 2'd0, 2'd0, 2'd0, 4'hC, 0);
    run_cmd(3'b100, 2'd1, 2'd0, 2'd0, 4'hA, 0);
    run_cmd(3'b001, 2'd2, 2'd0, 2'd1, 4'h0, 0);   // 0x2
    run_cmd(3'b010, 2'd2, 2'd0, 2'd1, 4'h0, 0);   // 0x8
    run_cmd(3'b011, 2'd2, 2'd0, 2'd1, 4'h0, 0);   // 0xE
    check_regs("sao_regs");

    run_cmd(3'b000, 2'd3, 2'd0, 2'd1, 4'h0, 10);  // back-pressure
    check_regs("bp_regs");

    run_cmd(3'b111, 2'd0, 2'd1, 2'd2, 4'h9, 0);   // reserved
    check_regs("rsv_regs");

    run_cmd(3'b100, 2'd3, 2'd0, 2'd0, 4'h3, 0);
    run_cmd(3'b000, 2'd3, 2'd3, 2'd3, 4'h0, 0);   // aliasing -> 6
    check("alias_r3", dut.u_rf.regs_q[3], 8'h06);

    for (int k = 0; k < 24; k++)
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    check_regs("rand_regs");

    // Reset during EXEC: the command must never write back or respond.
    run_cmd(3'b100, 2'd1, 2'd0, 2'd0, 4'h7, 0);
    req_valid = 1'b1; req_cmd = 3'b000; req_dst = 2'd1; req_src_a = 2'd1; req_src_b = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_exec_sel", alu_a, 8'h07);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rvld", resp_valid, 0);
    check("mid_rdy", req_ready, 0);
    check("mid_alu_a", alu_a, 0);
    check("mid_flags", resp_flags, 0);
    check_regs("mid_regs");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_post_rvld", resp_valid, 0);
      check("mid_post_rdy", req_ready, 1);
    end
    check_regs("mid_post_regs");
    check("sb_empty", 8'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
